// File: rtl/hh_pkg.sv
// -----------------------------------------------------------------------------
// hh_pkg
// Shared types and constants for the Hodgkin-Huxley step scheduler slice.
//   state_e   : scheduler FSM states
//   ctx_t     : per-neuron context {v, n, m, h}, 8 bits each, v in the MSBs
//   *_DEF     : default reset values of a neuron context
//   cnt_width : width of a refractory counter able to hold REFRACT_STEPS
// -----------------------------------------------------------------------------
package hh_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [7:0] v;
        logic [7:0] n;
        logic [7:0] m;
        logic [7:0] h;
    } ctx_t;

    localparam logic [7:0] V_RESET_DEF = 8'd0;
    localparam logic [7:0] N_INIT_DEF  = 8'd8;
    localparam logic [7:0] M_INIT_DEF  = 8'd2;
    localparam logic [7:0] H_INIT_DEF  = 8'd4;

    // A zero-step refractory period still needs a 1-bit counter so the
    // storage never collapses to a zero-width vector.
    function automatic int cnt_width(input int steps);
        return (steps > 0) ? $clog2(steps + 1) : 1;
    endfunction

endpackage

// File: rtl/hh_ctx_regfile.sv
// -----------------------------------------------------------------------------
// hh_ctx_regfile
// Storage for NUM_NEURONS neuron contexts, their stimulus currents and their
// refractory counters.
//   clk, rst_n   : clock, synchronous active-low reset (restores init values)
//   rd_idx       : neuron selected for the combinational read and for the
//                  context/counter write ports
//   rd_ctx       : context {v,n,m,h} of rd_idx
//   rd_stim      : stimulus of rd_idx
//   rd_cnt       : refractory counter of rd_idx
//   wb_we/wb_ctx : context writeback at rd_idx
//   cnt_we/cnt_wdata : refractory counter write at rd_idx
//   cfg_we/cfg_addr/cfg_stim : independent stimulus write port; addresses at
//                  or beyond NUM_NEURONS are dropped
// -----------------------------------------------------------------------------
module hh_ctx_regfile
    import hh_pkg::*;
#(
    parameter int         NUM_NEURONS = 4,
    parameter int         IDX_W       = $clog2(NUM_NEURONS),
    parameter int         CNT_W       = 2,
    parameter logic [7:0] V_RESET     = V_RESET_DEF,
    parameter logic [7:0] N_INIT      = N_INIT_DEF,
    parameter logic [7:0] M_INIT      = M_INIT_DEF,
    parameter logic [7:0] H_INIT      = H_INIT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_ctx,
    output logic [7:0]       rd_stim,
    output logic [CNT_W-1:0] rd_cnt,
    input  logic             wb_we,
    input  logic [31:0]      wb_ctx,
    input  logic             cnt_we,
    input  logic [CNT_W-1:0] cnt_wdata,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [7:0]       cfg_stim
);

    localparam logic [IDX_W:0] NN_EXT = (IDX_W + 1)'(NUM_NEURONS);
    localparam ctx_t CTX_INIT = '{v: V_RESET, n: N_INIT, m: M_INIT, h: H_INIT};

    ctx_t             ctx_q  [NUM_NEURONS];
    ctx_t             ctx_d  [NUM_NEURONS];
    logic [7:0]       stim_q [NUM_NEURONS];
    logic [7:0]       stim_d [NUM_NEURONS];
    logic [CNT_W-1:0] cnt_q  [NUM_NEURONS];
    logic [CNT_W-1:0] cnt_d  [NUM_NEURONS];

    assign rd_ctx  = ctx_q[rd_idx];
    assign rd_stim = stim_q[rd_idx];
    assign rd_cnt  = cnt_q[rd_idx];

    always_comb begin
        ctx_d  = ctx_q;
        stim_d = stim_q;
        cnt_d  = cnt_q;
        if (wb_we) begin
            ctx_d[rd_idx] = ctx_t'(wb_ctx);
        end
        if (cnt_we) begin
            cnt_d[rd_idx] = cnt_wdata;
        end
        // Guard matters only when NUM_NEURONS is not a power of two.
        if (cfg_we && ({1'b0, cfg_addr} < NN_EXT)) begin
            stim_d[cfg_addr] = cfg_stim;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                ctx_q[i]  <= CTX_INIT;
                stim_q[i] <= 8'd0;
                cnt_q[i]  <= '0;
            end
        end else begin
            ctx_q  <= ctx_d;
            stim_q <= stim_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/hh_step_scheduler.sv
// -----------------------------------------------------------------------------
// hh_step_scheduler
// Time-multiplexes one shared 8-bit Hodgkin-Huxley datapath across
// NUM_NEURONS neuron contexts. Each tick walks neurons 0..N-1: refractory
// neurons are clamped to V_RESET in one cycle, active neurons are issued to
// the datapath and their result written back when dp_done returns.
//   clk, rst_n        : clock, synchronous active-low reset
//   tick              : start one timestep (ignored and flagged while busy)
//   cfg_we/addr/stim  : stimulus current write, accepted at any time
//   busy              : a step is in progress (ISSUE, WAIT or DONE)
//   step_done         : one-cycle pulse in the final cycle of a step
//   spike_vec         : spike bitmap of the last completed step
//   overrun           : sticky, a tick arrived while busy
//   dp_start          : one-cycle issue strobe; dp_v/n/m/h/stim valid with it
//   dp_done, dp_*_next, dp_spike : datapath result, valid for one cycle
// -----------------------------------------------------------------------------
module hh_step_scheduler
    import hh_pkg::*;
#(
    parameter int         NUM_NEURONS   = 4,
    parameter int         IDX_W         = $clog2(NUM_NEURONS),
    parameter int         REFRACT_STEPS = 2,
    parameter logic [7:0] V_RESET       = V_RESET_DEF,
    parameter logic [7:0] N_INIT        = N_INIT_DEF,
    parameter logic [7:0] M_INIT        = M_INIT_DEF,
    parameter logic [7:0] H_INIT        = H_INIT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick,
    input  logic                   cfg_we,
    input  logic [IDX_W-1:0]       cfg_addr,
    input  logic [7:0]             cfg_stim,
    output logic                   busy,
    output logic                   step_done,
    output logic [NUM_NEURONS-1:0] spike_vec,
    output logic                   overrun,
    output logic                   dp_start,
    output logic [7:0]             dp_v,
    output logic [7:0]             dp_n,
    output logic [7:0]             dp_m,
    output logic [7:0]             dp_h,
    output logic [7:0]             dp_stim,
    input  logic                   dp_done,
    input  logic [7:0]             dp_v_next,
    input  logic [7:0]             dp_n_next,
    input  logic [7:0]             dp_m_next,
    input  logic [7:0]             dp_h_next,
    input  logic                   dp_spike
);

    localparam int               CNT_W      = cnt_width(REFRACT_STEPS);
    localparam logic [CNT_W-1:0] REFRACT_LD = CNT_W'(REFRACT_STEPS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_NEURONS - 1);

    state_e                 state_q,     state_d;
    logic [IDX_W-1:0]       idx_q,       idx_d;
    logic [NUM_NEURONS-1:0] shadow_q,    shadow_d;
    logic [NUM_NEURONS-1:0] spike_vec_q, spike_vec_d;
    logic                   overrun_q,   overrun_d;

    logic [31:0]      rd_ctx_raw;
    ctx_t             rd_c;
    logic [7:0]       rd_stim;
    logic [CNT_W-1:0] rd_cnt;
    ctx_t             wb_ctx;
    logic             wb_we;
    logic             cnt_we;
    logic [CNT_W-1:0] cnt_wdata;
    logic             advance;

    hh_ctx_regfile #(
        .NUM_NEURONS (NUM_NEURONS),
        .IDX_W       (IDX_W),
        .CNT_W       (CNT_W),
        .V_RESET     (V_RESET),
        .N_INIT      (N_INIT),
        .M_INIT      (M_INIT),
        .H_INIT      (H_INIT)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (idx_q),
        .rd_ctx    (rd_ctx_raw),
        .rd_stim   (rd_stim),
        .rd_cnt    (rd_cnt),
        .wb_we     (wb_we),
        .wb_ctx    (wb_ctx),
        .cnt_we    (cnt_we),
        .cnt_wdata (cnt_wdata),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_stim  (cfg_stim)
    );

    assign rd_c = ctx_t'(rd_ctx_raw);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        spike_vec_d = spike_vec_q;
        overrun_d   = overrun_q;
        wb_we       = 1'b0;
        wb_ctx      = rd_c;
        cnt_we      = 1'b0;
        cnt_wdata   = rd_cnt;
        dp_start    = 1'b0;
        advance     = 1'b0;

        // DONE still counts as busy, so a tick there is an overrun too.
        if (tick && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d  = ST_ISSUE;
                    idx_d    = '0;
                    shadow_d = '0;
                end
            end
            ST_ISSUE: begin
                if (rd_cnt != '0) begin
                    // Refractory: burn one step, clamp V, keep the gates.
                    cnt_we    = 1'b1;
                    cnt_wdata = rd_cnt - 1'b1;
                    wb_we     = 1'b1;
                    wb_ctx.v  = V_RESET;
                    advance   = 1'b1;
                end else begin
                    dp_start = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dp_done) begin
                    wb_we           = 1'b1;
                    wb_ctx.v        = dp_v_next;
                    wb_ctx.n        = dp_n_next;
                    wb_ctx.m        = dp_m_next;
                    wb_ctx.h        = dp_h_next;
                    shadow_d[idx_q] = dp_spike;
                    if (dp_spike && (REFRACT_STEPS > 0)) begin
                        cnt_we    = 1'b1;
                        cnt_wdata = REFRACT_LD;
                    end
                    advance = 1'b1;
                end
            end
            ST_DONE: begin
                spike_vec_d = shadow_q;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (advance) begin
            if (idx_q == LAST_IDX) begin
                state_d = ST_DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = ST_ISSUE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            shadow_q    <= '0;
            spike_vec_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            spike_vec_q <= spike_vec_d;
            overrun_q   <= overrun_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign step_done = (state_q == ST_DONE);
    assign spike_vec = spike_vec_q;
    assign overrun   = overrun_q;

    // Operands follow the read port; they only mean something with dp_start.
    assign dp_v    = rd_c.v;
    assign dp_n    = rd_c.n;
    assign dp_m    = rd_c.m;
    assign dp_h    = rd_c.h;
    assign dp_stim = rd_stim;

endmodule

// File: tb/tb_hh_step_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hh_step_scheduler
// Bench for hh_step_scheduler (4 neurons, 2 refractory steps). A behavioural
// datapath answers each dp_start after a programmable latency with
// v+10+stim/2, n+1, m+3, h+5 and spikes when the stimulus is odd. A per-step
// neuron-list model predicts every issue cycle/operand set, the step length
// and the spike bitmap.
// -----------------------------------------------------------------------------
module tb_hh_step_scheduler;

    localparam int NN = 4;
    localparam int RS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_addr = 2'd0;
    logic [7:0]    cfg_stim = 8'd0;
    logic          busy, step_done, overrun, dp_start;
    logic [NN-1:0] spike_vec;
    logic [7:0]    dp_v, dp_n, dp_m, dp_h, dp_stim;
    logic          dp_done = 1'b0;
    logic [7:0]    dp_v_next = 8'd0, dp_n_next = 8'd0, dp_m_next = 8'd0, dp_h_next = 8'd0;
    logic          dp_spike = 1'b0;

    always #5 clk = ~clk;

    hh_step_scheduler #(.NUM_NEURONS(NN), .REFRACT_STEPS(RS)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_stim(cfg_stim),
        .busy(busy), .step_done(step_done), .spike_vec(spike_vec), .overrun(overrun),
        .dp_start(dp_start), .dp_v(dp_v), .dp_n(dp_n), .dp_m(dp_m), .dp_h(dp_h),
        .dp_stim(dp_stim), .dp_done(dp_done), .dp_v_next(dp_v_next),
        .dp_n_next(dp_n_next), .dp_m_next(dp_m_next), .dp_h_next(dp_h_next),
        .dp_spike(dp_spike)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dp_fn(input logic [7:0] v, n, m, h, s);
        logic [7:0] v2, n2, m2, h2;
        v2 = v + 8'd10 + (s >> 1);
        n2 = n + 8'd1;
        m2 = m + 8'd3;
        h2 = h + 8'd5;
        return {v2, n2, m2, h2};
    endfunction

    // ---------------- behavioural datapath ----------------
    int         cyc = 0;
    int         lat = 2;
    bit         pend = 1'b0;
    int         due = 0;
    logic [7:0] rv, rn, rm, rh, rs;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        dp_done = 1'b0;
        if (pend && cyc == due) begin
            dp_done = 1'b1;
            {dp_v_next, dp_n_next, dp_m_next, dp_h_next} = dp_fn(rv, rn, rm, rh, rs);
            dp_spike = rs[0];
            pend = 1'b0;
        end
        if (dp_start && !pend) begin
            pend = 1'b1;
            due  = cyc + lat;
            rv = dp_v; rn = dp_n; rm = dp_m; rh = dp_h; rs = dp_stim;
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int off;
        int nid;
        logic [7:0] v, n, m, h, s;
    } iss_t;

    logic [7:0] m_v [NN];
    logic [7:0] m_n [NN];
    logic [7:0] m_m [NN];
    logic [7:0] m_h [NN];
    logic [7:0] m_s [NN];
    int         m_r [NN];
    iss_t       exp_q[$];
    int         exp_done;
    logic [3:0] exp_sv;

    task automatic model_reset();
        for (int i = 0; i < NN; i++) begin
            m_v[i] = 8'd0; m_n[i] = 8'd8; m_m[i] = 8'd2; m_h[i] = 8'd4;
            m_s[i] = 8'd0; m_r[i] = 0;
        end
    endtask

    // Walks the neuron list once; a cfg write at cycle inj_off is seen by
    // any neuron whose issue cycle is later than inj_off.
    task automatic model_step(input int l, input int inj_off, input int inj_addr,
                              input logic [7:0] inj_val);
        int   t;
        bit   ip;
        iss_t e;
        exp_q.delete();
        exp_sv = 4'b0;
        t  = 1;
        ip = (inj_off >= 0);
        for (int i = 0; i < NN; i++) begin
            if (ip && inj_off < t) begin m_s[inj_addr] = inj_val; ip = 1'b0; end
            if (m_r[i] > 0) begin
                m_r[i]--;
                m_v[i] = 8'd0;
                t += 1;
            end else begin
                e.off = t; e.nid = i;
                e.v = m_v[i]; e.n = m_n[i]; e.m = m_m[i]; e.h = m_h[i]; e.s = m_s[i];
                exp_q.push_back(e);
                {m_v[i], m_n[i], m_m[i], m_h[i]} = dp_fn(e.v, e.n, e.m, e.h, e.s);
                if (e.s[0]) begin exp_sv[i] = 1'b1; m_r[i] = RS; end
                t += l + 1;
            end
        end
        if (ip) m_s[inj_addr] = inj_val;
        exp_done = t;
    endtask

    task automatic cfg_write(input int a, input logic [7:0] v);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a[1:0]; cfg_stim = v;
        @(negedge clk);
        cfg_we = 1'b0;
        m_s[a] = v;
    endtask

    // One timestep, cycle by cycle. Cycle t is sampled and driven at its
    // falling edge; t=0 carries the tick. rst_nid>=0 pulls reset during the
    // first WAIT cycle of that neuron.
    task automatic run_step(input int l, input int inj_off, input int inj_addr,
                            input logic [7:0] inj_val, input int tick2, input int rst_nid,
                            output int done_off, output int n_iss, output logic [7:0] first_stim);
        int qi, lim, rst_off;
        bit es;
        qi = 0; done_off = -1; n_iss = 0; first_stim = 8'd0; rst_off = -1;
        lat = l;
        model_step(l, inj_off, inj_addr, inj_val);
        for (int k = 0; k < exp_q.size(); k++)
            if (exp_q[k].nid == rst_nid) rst_off = exp_q[k].off + 1;
        lim = ((exp_done > inj_off) ? exp_done : inj_off) + 3;
        if (rst_off >= 0) lim = rst_off + 20;
        for (int t = 0; t <= lim; t++) begin
            @(negedge clk);
            if (rst_off < 0 || t <= rst_off) begin
                es = (qi < exp_q.size()) && (exp_q[qi].off == t);
                chk("dp_start", dp_start, es);
                if (dp_start && es) begin
                    chk("operands", {dp_v, dp_n, dp_m, dp_h, dp_stim},
                        {exp_q[qi].v, exp_q[qi].n, exp_q[qi].m, exp_q[qi].h, exp_q[qi].s});
                    qi++;
                end
                chk("busy", busy, (t >= 1 && t <= exp_done));
                chk("step_done", step_done, (t == exp_done));
            end else begin
                chk("busy_after_rst", busy, 1'b0);
                chk("done_after_rst", step_done, 1'b0);
                chk("start_after_rst", dp_start, 1'b0);
            end
            if (dp_start) begin
                n_iss++;
                if (n_iss == 1) first_stim = dp_stim;
            end
            if (step_done && done_off < 0) done_off = t;
            tick     = (t == 0) || (t == tick2);
            cfg_we   = (t == inj_off);
            cfg_addr = inj_addr[1:0];
            cfg_stim = inj_val;
            rst_n    = (t != rst_off);
        end
        if (rst_off < 0) begin
            chk("spike_vec", spike_vec, exp_sv);
            chk("issue_count", n_iss, exp_q.size());
        end
    endtask

    typedef struct {
        logic [31:0] stims;   // neuron i at [8*i +: 8]
        int          lat;
        int          done;
        logic [3:0]  sv;
        int          iss;
    } vec_t;

    vec_t       tbl [7];
    int         d, ni;
    logic [7:0] fs;

    initial begin
        tbl[0] = '{32'h00_00_00_00, 2, 13, 4'b0000, 4};
        tbl[1] = '{32'h00_28_01_00, 2, 13, 4'b0010, 4};  // n1 spikes, n2 stim 40
        tbl[2] = '{32'h00_28_01_00, 2, 11, 4'b0000, 3};  // n1 refractory
        tbl[3] = '{32'h00_28_01_00, 2, 11, 4'b0000, 3};  // n1 refractory
        tbl[4] = '{32'h00_28_01_00, 2, 13, 4'b0010, 4};  // n1 issued again
        tbl[5] = '{32'h00_00_00_00, 1,  8, 4'b0000, 3};
        tbl[6] = '{32'h05_00_00_03, 3, 14, 4'b1001, 3};

        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_step_done", step_done, 1'b0);
        chk("rst_spike_vec", spike_vec, 4'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_dp_start", dp_start, 1'b0);

        // second tick 3 cycles in: flagged, step still finishes once at 13
        run_step(2, -1, 0, 8'd0, 3, -1, d, ni, fs);
        chk("ovr_done_cycle", d, 13);
        chk("ovr_issues", ni, 4);
        chk("overrun_set", overrun, 1'b1);

        // L=5, stim write to neuron 0 while it is in WAIT
        run_step(5, 3, 0, 8'd6, -1, -1, d, ni, fs);
        chk("l5_old_stim", fs, 8'd0);
        chk("l5_done_cycle", d, 25);
        run_step(2, -1, 0, 8'd0, -1, -1, d, ni, fs);
        chk("l5_new_stim", fs, 8'd6);

        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < NN; i++) cfg_write(i, tbl[k].stims[8*i +: 8]);
            run_step(tbl[k].lat, -1, 0, 8'd0, -1, -1, d, ni, fs);
            chk("tbl_done_cycle", d, tbl[k].done);
            chk("tbl_spike_vec", spike_vec, tbl[k].sv);
            chk("tbl_issues", ni, tbl[k].iss);
        end
        chk("overrun_sticky", overrun, 1'b1);

        // reset during WAIT of neuron 2; its dp_done lands after release
        for (int i = 0; i < NN; i++) cfg_write(i, 8'd0);
        run_step(2, -1, 0, 8'd0, -1, 2, d, ni, fs);
        chk("rst_mid_no_done", d, -1);
        chk("rst_mid_spike_vec", spike_vec, 4'b0);
        chk("rst_mid_overrun", overrun, 1'b0);
        model_reset();
        run_step(2, -1, 0, 8'd0, -1, -1, d, ni, fs);
        chk("post_rst_done_cycle", d, 13);

        // randomized steps against the model
        for (int k = 0; k < 30; k++) begin
            int nw, l, io;
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++)
                cfg_write($urandom_range(0, NN - 1), 8'($urandom_range(0, 255)));
            l  = $urandom_range(1, 4);
            io = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : -1;
            run_step(l, io, $urandom_range(0, NN - 1), 8'($urandom_range(0, 255)),
                     -1, -1, d, ni, fs);
            chk("rnd_done_cycle", d, exp_done);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
